parc_mem_arbiter: RTL and testbench

- Sits directly downstream of the five-stage PARC core.
- Merges the core's instruction port (imem_*) and data port (dmem_*) onto one single-ported memory bus with a valid/ready request channel and a valid response channel.
- Data requests have fixed priority, with a starvation guard for fetch.
- One transaction is outstanding at a time, and a watchdog converts lost responses into error responses.

---
 rtl/parc_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_parc_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parc_mem_arbiter.sv
// Merges the PARC core's fetch and data ports onto one single-ported memory bus.
// Data wins ties unless fetch has been starved; a watchdog turns lost responses into error responses.
module parc_mem_arbiter #(
   parameter int XLEN         = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT_CYC  = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] imem_addr,
   input  logic            imem_req,
   output logic [XLEN-1:0] imem_data,
   output logic            imem_resp,
   input  logic [XLEN-1:0] dmem_addr,
   input  logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_we,
   input  logic            dmem_req,
   output logic [XLEN-1:0] dmem_data,
   output logic            dmem_resp,
   output logic            mem_req_val,
   input  logic            mem_req_rdy,
   output logic [XLEN-1:0] mem_req_addr,
   output logic            mem_req_we,
   output logic [XLEN-1:0] mem_req_wdata,
   input  logic            mem_resp_val,
   input  logic [XLEN-1:0] mem_resp_data,
   output logic            err
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t          state;
   state_t          state_next;

   logic            owner_d;
   logic [XLEN-1:0] addr_q;
   logic            we_q;
   logic [XLEN-1:0] wdata_q;
   logic [SW-1:0]   starve_cnt;
   logic [TW-1:0]   tmo_cnt;

   logic            any_req;
   logic            grant_i;
   logic            starved;
   logic            tmo_hit;

   // Fetch wins only when data is idle or fetch has waited through STARVE_LIMIT data grants
   assign any_req = imem_req | dmem_req;
   assign starved = (starve_cnt == SW'(STARVE_LIMIT));
   assign grant_i = imem_req & (~dmem_req | starved);
   assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE:  if (any_req) state_next = ST_ISSUE;
         ST_ISSUE: if (mem_req_rdy) state_next = ST_WAIT;
         ST_WAIT:  if (mem_resp_val || tmo_hit) state_next = ST_RESP;
         ST_RESP:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_req_val = (state == ST_ISSUE);
      imem_resp   = (state == ST_RESP) && !owner_d;
      dmem_resp   = (state == ST_RESP) && owner_d;
   end

   assign mem_req_addr  = addr_q;
   assign mem_req_we    = we_q;
   assign mem_req_wdata = wdata_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_d    <= 1'b0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         starve_cnt <= '0;
         tmo_cnt    <= '0;
         imem_data  <= '0;
         dmem_data  <= '0;
         err        <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (!imem_req || grant_i) begin
                  starve_cnt <= '0;
               end else if (dmem_req && !starved) begin
                  starve_cnt <= starve_cnt + SW'(1);
               end
               if (any_req) begin
                  if (grant_i) begin
                     owner_d <= 1'b0;
                     addr_q  <= imem_addr;
                     we_q    <= 1'b0;
                     wdata_q <= '0;
                  end else begin
                     owner_d <= 1'b1;
                     addr_q  <= dmem_addr;
                     we_q    <= dmem_we;
                     wdata_q <= dmem_wdata;
                  end
               end
            end
            ST_ISSUE: begin
               if (mem_req_rdy) tmo_cnt <= '0;
            end
            ST_WAIT: begin
               tmo_cnt <= tmo_cnt + TW'(1);
               // A response arriving in the final timeout cycle still counts as good
               if (mem_resp_val) begin
                  if (owner_d) dmem_data <= mem_resp_data;
                  else         imem_data <= mem_resp_data;
               end else if (tmo_hit) begin
                  err <= 1'b1;
                  if (owner_d) dmem_data <= '0;
                  else         imem_data <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_parc_mem_arbiter.sv
// Directed bench for parc_mem_arbiter: fetch, store, contention, timeout race, timeout, reset.
module tb_parc_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic [31:0] imem_data;
   logic        imem_resp;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_we;
   logic        dmem_req;
   logic [31:0] dmem_data;
   logic        dmem_resp;
   logic        mem_req_val;
   logic        mem_req_rdy;
   logic [31:0] mem_req_addr;
   logic        mem_req_we;
   logic [31:0] mem_req_wdata;
   logic        mem_resp_val;
   logic [31:0] mem_resp_data;
   logic        err;

   int checkCount = 0;
   int errorCount = 0;

   parc_mem_arbiter #(
      .XLEN(32),
      .STARVE_LIMIT(4),
      .TIMEOUT_CYC(255)
   ) dut (
      .clk(clk),
      .rst(rst),
      .imem_addr(imem_addr),
      .imem_req(imem_req),
      .imem_data(imem_data),
      .imem_resp(imem_resp),
      .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata),
      .dmem_we(dmem_we),
      .dmem_req(dmem_req),
      .dmem_data(dmem_data),
      .dmem_resp(dmem_resp),
      .mem_req_val(mem_req_val),
      .mem_req_rdy(mem_req_rdy),
      .mem_req_addr(mem_req_addr),
      .mem_req_we(mem_req_we),
      .mem_req_wdata(mem_req_wdata),
      .mem_resp_val(mem_resp_val),
      .mem_resp_data(mem_resp_data),
      .err(err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                                input logic [31:0] daddr, input logic dwe, input logic [31:0] dwdata);
      imem_req   = ireq;
      imem_addr  = iaddr;
      dmem_req   = dreq;
      dmem_addr  = daddr;
      dmem_we    = dwe;
      dmem_wdata = dwdata;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      logic expD;
      rst           = 1'b0;
      mem_req_rdy   = 1'b0;
      mem_resp_val  = 1'b0;
      mem_resp_data = '0;
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

      #12;
      checkOutput("reset_req_val", {31'b0, mem_req_val}, 32'd0);
      checkOutput("reset_err", {31'b0, err}, 32'd0);
      checkOutput("reset_imem_data", imem_data, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      stepCycle();

      // Single fetch with minimum latency; stray resp_val during ISSUE is ignored
      $display("[TB] single fetch");
      applyStimulus(1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0, 32'h0);
      mem_req_rdy = 1'b1;
      stepCycle();
      checkOutput("fetch_req_val", {31'b0, mem_req_val}, 32'd1);
      checkOutput("fetch_req_addr", mem_req_addr, 32'h8000_0000);
      checkOutput("fetch_req_we", {31'b0, mem_req_we}, 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      mem_resp_val  = 1'b1;
      mem_resp_data = 32'h2402_0005;
      stepCycle();
      checkOutput("fetch_wait_val", {31'b0, mem_req_val}, 32'd0);
      checkOutput("fetch_wait_resp", {31'b0, imem_resp}, 32'd0);
      stepCycle();
      checkOutput("fetch_imem_resp", {31'b0, imem_resp}, 32'd1);
      checkOutput("fetch_dmem_resp", {31'b0, dmem_resp}, 32'd0);
      checkOutput("fetch_imem_data", imem_data, 32'h2402_0005);
      mem_resp_val = 1'b0;
      stepCycle();
      checkOutput("fetch_resp_drop", {31'b0, imem_resp}, 32'd0);

      // Store held in ISSUE while the bus is not ready
      $display("[TB] store with backpressure");
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 32'hCAFE_F00D);
      mem_req_rdy = 1'b0;
      stepCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) mem_req_rdy = 1'b1;
         checkOutput($sformatf("store_val_%0d", i), {31'b0, mem_req_val}, 32'd1);
         checkOutput($sformatf("store_addr_%0d", i), mem_req_addr, 32'h100);
         checkOutput($sformatf("store_we_%0d", i), {31'b0, mem_req_we}, 32'd1);
         checkOutput($sformatf("store_wdata_%0d", i), mem_req_wdata, 32'hCAFE_F00D);
         stepCycle();
      end
      checkOutput("store_val_off", {31'b0, mem_req_val}, 32'd0);
      mem_resp_val  = 1'b1;
      mem_resp_data = 32'h1234_5678;
      stepCycle();
      checkOutput("store_dmem_resp", {31'b0, dmem_resp}, 32'd1);
      checkOutput("store_imem_resp", {31'b0, imem_resp}, 32'd0);
      checkOutput("store_dmem_data", dmem_data, 32'h1234_5678);
      checkOutput("imem_data_held", imem_data, 32'h2402_0005);
      mem_resp_val = 1'b0;
      stepCycle();
      checkOutput("store_resp_once", {31'b0, dmem_resp}, 32'd0);

      // Contention: expected grant order D, D, D, D, I, D
      $display("[TB] contention and starvation");
      applyStimulus(1'b1, 32'h8000_1000, 1'b1, 32'h200, 1'b0, 32'h0);
      for (int i = 0; i < 6; i++) begin
         expD = (i != 4);
         stepCycle();
         checkOutput($sformatf("grant_addr_%0d", i), mem_req_addr, expD ? 32'h200 : 32'h8000_1000);
         mem_resp_val  = 1'b1;
         mem_resp_data = 32'h1000 + i;
         stepCycle();
         stepCycle();
         checkOutput($sformatf("grant_dresp_%0d", i), {31'b0, dmem_resp}, {31'b0, expD});
         checkOutput($sformatf("grant_iresp_%0d", i), {31'b0, imem_resp}, {31'b0, ~expD});
         checkOutput($sformatf("grant_data_%0d", i), expD ? dmem_data : imem_data, 32'h1000 + i);
         mem_resp_val = 1'b0;
         stepCycle();
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      stepCycle();

      // Response in the final timeout cycle wins over the watchdog
      $display("[TB] timeout race");
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h300, 1'b0, 32'h0);
      stepCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      stepCycle();
      repeat (254) stepCycle();
      checkOutput("race_no_early_resp", {31'b0, dmem_resp}, 32'd0);
      mem_resp_val  = 1'b1;
      mem_resp_data = 32'hABCD_1234;
      stepCycle();
      checkOutput("race_dmem_resp", {31'b0, dmem_resp}, 32'd1);
      checkOutput("race_dmem_data", dmem_data, 32'hABCD_1234);
      checkOutput("race_err", {31'b0, err}, 32'd0);
      stepCycle();

      $display("[TB] stray response in IDLE");
      for (int i = 0; i < 2; i++) begin
         stepCycle();
         checkOutput($sformatf("stray_iresp_%0d", i), {31'b0, imem_resp}, 32'd0);
         checkOutput($sformatf("stray_dresp_%0d", i), {31'b0, dmem_resp}, 32'd0);
      end
      mem_resp_val = 1'b0;

      $display("[TB] timeout");
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h400, 1'b0, 32'h0);
      stepCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      stepCycle();
      n = 0;
      while (n < 400 && !dmem_resp) begin
         stepCycle();
         n++;
      end
      checkOutput("timeout_cycles", n, 32'd255);
      checkOutput("timeout_dmem_data", dmem_data, 32'h0);
      checkOutput("timeout_err", {31'b0, err}, 32'd1);
      stepCycle();
      applyStimulus(1'b1, 32'h8000_0004, 1'b0, 32'h0, 1'b0, 32'h0);
      stepCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      mem_resp_val  = 1'b1;
      mem_resp_data = 32'h0000_0055;
      stepCycle();
      stepCycle();
      checkOutput("after_to_iresp", {31'b0, imem_resp}, 32'd1);
      checkOutput("after_to_idata", imem_data, 32'h0000_0055);
      checkOutput("err_sticky", {31'b0, err}, 32'd1);
      mem_resp_val = 1'b0;
      stepCycle();

      // Asynchronous reset while a fetch is waiting on the bus
      $display("[TB] reset mid-WAIT");
      applyStimulus(1'b1, 32'h8000_2000, 1'b0, 32'h0, 1'b0, 32'h0);
      stepCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      stepCycle();
      #2 rst = 1'b0;
      #1;
      checkOutput("rst_err", {31'b0, err}, 32'd0);
      checkOutput("rst_imem_data", imem_data, 32'h0);
      checkOutput("rst_dmem_data", dmem_data, 32'h0);
      checkOutput("rst_req_addr", mem_req_addr, 32'h0);
      checkOutput("rst_req_val", {31'b0, mem_req_val}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      mem_resp_val  = 1'b1;
      mem_resp_data = 32'h0000_0077;
      for (int i = 0; i < 3; i++) begin
         stepCycle();
         checkOutput($sformatf("late_iresp_%0d", i), {31'b0, imem_resp}, 32'd0);
         checkOutput($sformatf("late_req_val_%0d", i), {31'b0, mem_req_val}, 32'd0);
      end
      checkOutput("late_imem_data", imem_data, 32'h0);
      mem_resp_val = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
